game_sequencer: RTL
===================

# game_sequencer

Per-frame game-logic scheduler for Breakout. Once per VGA frame it sequences the paddle update, ball motion, wall/brick/paddle collision resolution, brick clearing, scoring and life accounting, then publishes a consistent snapshot to the colour/render logic. It sits between the VGA timing generator (frame tick), the checkButton debouncers (left/right/launch) and the colour module (consumer of all position and brick-alive outputs).

## Interface
- BRICKS, 12: number of bricks in the wall, 6 per row.
- LIVES_INIT, 3: lives at game start.
- CLOCK_50  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse, start of vertical blank.
- left, right  in  1  level, button held.
- launch  in  1  one-cycle pulse: serve the ball, or restart after game end.
- paddle_x  out  10  paddle left column.
- ball_row  out  9  ball top row; ball is 4x4 pixels.
- ball_col  out  10  ball left column.
- brick_alive  out  BRICKS  bit i = brick i present.
- score  out  4  bricks broken.
- lives  out  2  remaining lives.
- game_state  out  2  READY=0, PLAY=1, OVER=2, WON=3.
- busy  out  1  update sequence in progress.

## Operation
- Geometry constants, inclusive bounds:
  - playfield columns 40..589; top wall ends at row 29; paddle rows 440..459, width 64, step 5.
  - Brick row A: rows 100..129, left edges 40/140/240/340/440/540, widths 100 ×5 then 50.
  - Brick row B: rows 150..179, left edges 40/90/190/290/390/490, widths 50 then 100 ×5.
- Phase FSM: WAIT → PAD → BALL → WALL → BRICK (12 cycles, index 0..11) → HIT → COMMIT → WAIT. Work is done on scratch registers; outputs load only in COMMIT.
- PAD:
  - left only: move −5 if paddle_x ≥ 45.
  - right only: move +5 if paddle_x ≤ 520.
  - both or neither: hold.
- BALL:
  - PLAY: row ±2 (up/down flag), col ±1 (left/right flag).
  - READY: ball rides the paddle at col = paddle_x+30, row = 436.
  - OVER/WON: ball frozen.
- WALL:
  - row < 30: row = 30, set down.
  - col < 40: col = 40, set right.
  - col+3 > 589: col = 586, set left.
- BRICK:
  - Index i checks alive brick i for rectangle overlap with the ball.
  - The first hit clears its bit, increments score and flips the vertical flag.
  - Remaining indices are skipped: at most one brick per frame.
- HIT:
  - Moving down and overlapping the paddle: set up, row = 436.
  - Otherwise, if row > 475: lives−1. Result 0 → OVER, else READY.
- COMMIT:
  - All bricks cleared → WON.
  - Pending launch in READY → PLAY, with up+right flags.
  - Pending launch in OVER/WON → full restart: all bricks alive, score 0, lives LIVES_INIT, READY, paddle_x 233.
- launch is latched as pending whenever it arrives; pending clears in COMMIT.
- Arithmetic:
  - Unsigned, 11-bit intermediates, so no subtraction underflows.
  - score saturates at 15.
  - lives never decrements below 0.

## Timing
- Reset values:
  - paddle_x 233, ball_row 436, ball_col 263.
  - brick_alive all 1, score 0, lives LIVES_INIT, game_state READY.
  - busy 0, FSM WAIT, launch pending cleared.
- frame_tick is sampled in WAIT at edge T. busy is high on T+1..T+17.
- Outputs change only at the COMMIT edge (T+17) and are stable for the rest of the frame.
- A frame_tick arriving while busy is dropped, with no queuing.
- launch coinciding with the COMMIT edge is taken in the following frame.
- reset_n asserted mid-sequence: immediate return to reset values; the partial frame is discarded.

## Configuration
- BALL_SPEEDUP_EN defined: once score ≥ 6, the vertical step is 3 instead of 2. The top-wall clamp and paddle snap are unchanged.
- Undefined: the vertical step is always 2.

## Structure
- breakout_pkg:
  - game_state_t and phase_t enums.
  - Brick left/width/top/height constant arrays.
  - Wall, paddle and ball-size constants.
  - The same package is shared by the colour/bricks render logic so geometry has a single source.
- One sub-module, rect_overlap: combinational axis-aligned overlap of two inclusive rectangles. Instantiated once for the brick scan (muxed by index) and once for the paddle check.

## Test plan
- Reset, then 3 ticks with right held → paddle_x 248; busy high exactly 17 cycles after each tick.
- Left held from paddle_x 45 → 40, then stays 40; both held → no change.
- Launch in READY; ball reaches row < 30 → row clamped to 30 and ball moves down the next frame.
- Ball aimed at brick 0 → brick_alive[0] = 0, score 1, direction flips; only one brick cleared even when two overlap.
- Paddle moved away; ball passes row 475 → lives 2, READY. Repeat to 0 → OVER; launch → full restart values.
- Tick asserted during busy → ignored. reset_n pulsed mid-BRICK → all reset values immediately.

Source files
------------

// File: rtl/breakout_pkg.sv
// breakout_pkg: Breakout geometry, game-state and sequencer-phase types shared by game logic and render logic.
package breakout_pkg;
    localparam int BRICKS     = 12;
    localparam int LIVES_INIT = 3;

    typedef enum logic [1:0] {READY = 2'd0, PLAY = 2'd1, OVER = 2'd2, WON = 2'd3} game_state_t;
    typedef enum logic [2:0] {WAIT, PAD, BALL, WALL, BRICK, HIT, COMMIT} phase_t;

    localparam logic [10:0] FIELD_L   = 11'd40;
    localparam logic [10:0] FIELD_R   = 11'd589;
    localparam logic [10:0] TOP_WALL  = 11'd29;
    localparam logic [10:0] PAD_TOP   = 11'd440;
    localparam logic [10:0] PAD_BOT   = 11'd459;
    localparam logic [10:0] PAD_W     = 11'd64;
    localparam logic [10:0] PAD_STEP  = 11'd5;
    localparam logic [10:0] PAD_MIN   = 11'd45;
    localparam logic [10:0] PAD_MAX   = 11'd520;
    localparam logic [10:0] PAD_INIT  = 11'd233;
    localparam logic [10:0] BALL_SIZE = 11'd4;
    localparam logic [10:0] BALL_OFS  = 11'd30;
    localparam logic [10:0] SNAP_ROW  = 11'd436;
    localparam logic [10:0] LOSE_ROW  = 11'd475;

    // Bricks 0..5 form row A, 6..11 form row B.
    localparam logic [10:0] BRICK_LEFT [BRICKS] = '{11'd40, 11'd140, 11'd240, 11'd340, 11'd440, 11'd540,
                                                    11'd40, 11'd90, 11'd190, 11'd290, 11'd390, 11'd490};
    localparam logic [10:0] BRICK_WIDTH [BRICKS] = '{11'd100, 11'd100, 11'd100, 11'd100, 11'd100, 11'd50,
                                                     11'd50, 11'd100, 11'd100, 11'd100, 11'd100, 11'd100};
    localparam logic [10:0] BRICK_TOP [BRICKS] = '{11'd100, 11'd100, 11'd100, 11'd100, 11'd100, 11'd100,
                                                   11'd150, 11'd150, 11'd150, 11'd150, 11'd150, 11'd150};
    localparam logic [10:0] BRICK_HEIGHT [BRICKS] = '{default: 11'd30};
endpackage

// File: rtl/rect_overlap.sv
// rect_overlap: combinational overlap test of two axis-aligned rectangles with inclusive bounds.
module rect_overlap (
    input  logic [10:0] a_l,
    input  logic [10:0] a_r,
    input  logic [10:0] a_t,
    input  logic [10:0] a_b,
    input  logic [10:0] b_l,
    input  logic [10:0] b_r,
    input  logic [10:0] b_t,
    input  logic [10:0] b_b,
    output logic        hit
);
    assign hit = (a_l <= b_r) && (b_l <= a_r) && (a_t <= b_b) && (b_t <= a_b);
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: per-frame Breakout update on scratch state, published at COMMIT; BALL_SPEEDUP_EN raises vertical step to 3 once score >= 6.
module game_sequencer
    import breakout_pkg::*;
(
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              frame_tick,
    input  logic              left,
    input  logic              right,
    input  logic              launch,
    output logic [9:0]        paddle_x,
    output logic [8:0]        ball_row,
    output logic [9:0]        ball_col,
    output logic [BRICKS-1:0] brick_alive,
    output logic [3:0]        score,
    output logic [1:0]        lives,
    output logic [1:0]        game_state,
    output logic              busy
);
    phase_t            phase, phase_n;
    game_state_t       gs_s, gs_n;
    logic [3:0]        idx, idx_n, score_s, score_n;
    logic [10:0]       pad_s, pad_n, row_s, row_n, col_s, col_n, vstep, ball_r, ball_b;
    logic [BRICKS-1:0] alive_s, alive_n;
    logic [1:0]        lives_s, lives_n;
    logic              go_down, go_down_n, go_right, go_right_n, hit_done, hit_done_n;
    logic              pend, brick_hit, pad_hit;

`ifdef BALL_SPEEDUP_EN
    assign vstep = (score_s >= 4'd6) ? 11'd3 : 11'd2;
`else
    assign vstep = 11'd2;
`endif

    assign busy   = phase != WAIT;
    assign ball_r = col_s + BALL_SIZE - 11'd1;
    assign ball_b = row_s + BALL_SIZE - 11'd1;

    rect_overlap u_brick (
        .a_l(col_s), .a_r(ball_r), .a_t(row_s), .a_b(ball_b),
        .b_l(BRICK_LEFT[idx]), .b_r(BRICK_LEFT[idx] + BRICK_WIDTH[idx] - 11'd1),
        .b_t(BRICK_TOP[idx]), .b_b(BRICK_TOP[idx] + BRICK_HEIGHT[idx] - 11'd1),
        .hit(brick_hit)
    );

    rect_overlap u_paddle (
        .a_l(col_s), .a_r(ball_r), .a_t(row_s), .a_b(ball_b),
        .b_l(pad_s), .b_r(pad_s + PAD_W - 11'd1), .b_t(PAD_TOP), .b_b(PAD_BOT),
        .hit(pad_hit)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) phase <= WAIT;
        else phase <= phase_n;

    always_comb begin
        phase_n    = phase;
        idx_n      = idx;
        pad_n      = pad_s;
        row_n      = row_s;
        col_n      = col_s;
        alive_n    = alive_s;
        score_n    = score_s;
        lives_n    = lives_s;
        gs_n       = gs_s;
        go_down_n  = go_down;
        go_right_n = go_right;
        hit_done_n = hit_done;
        case (phase)
            WAIT: phase_n = frame_tick ? PAD : WAIT;
            PAD: begin
                phase_n    = BALL;
                hit_done_n = 1'b0;
                if (left && !right && pad_s >= PAD_MIN) pad_n = pad_s - PAD_STEP;
                else if (right && !left && pad_s <= PAD_MAX) pad_n = pad_s + PAD_STEP;
            end
            BALL: begin
                phase_n = WALL;
                if (gs_s == PLAY) begin
                    row_n = go_down ? row_s + vstep : row_s - vstep;
                    col_n = go_right ? col_s + 11'd1 : col_s - 11'd1;
                end else if (gs_s == READY) begin
                    row_n = SNAP_ROW;
                    col_n = pad_s + BALL_OFS;
                end
            end
            WALL: begin
                phase_n = BRICK;
                idx_n   = 4'd0;
                if (row_s <= TOP_WALL) begin
                    row_n     = TOP_WALL + 11'd1;
                    go_down_n = 1'b1;
                end
                if (col_s < FIELD_L) begin
                    col_n      = FIELD_L;
                    go_right_n = 1'b1;
                end else if (col_s + 11'd3 > FIELD_R) begin
                    col_n      = FIELD_R - 11'd3;
                    go_right_n = 1'b0;
                end
            end
            BRICK: begin
                phase_n = (idx == 4'(BRICKS - 1)) ? HIT : BRICK;
                idx_n   = (idx == 4'(BRICKS - 1)) ? 4'd0 : idx + 4'd1;
                // Only the lowest-indexed overlapping brick breaks in a frame.
                if (!hit_done && alive_s[idx] && brick_hit) begin
                    alive_n[idx] = 1'b0;
                    score_n      = (score_s == 4'd15) ? 4'd15 : score_s + 4'd1;
                    go_down_n    = !go_down;
                    hit_done_n   = 1'b1;
                end
            end
            HIT: begin
                phase_n = COMMIT;
                if (gs_s == PLAY) begin
                    if (go_down && pad_hit) begin
                        go_down_n = 1'b0;
                        row_n     = SNAP_ROW;
                    end else if (row_s > LOSE_ROW) begin
                        lives_n = (lives_s == 2'd0) ? 2'd0 : lives_s - 2'd1;
                        gs_n    = (lives_s <= 2'd1) ? OVER : READY;
                    end
                end
            end
            COMMIT: begin
                phase_n = WAIT;
                if (pend && (gs_s == OVER || gs_s == WON)) begin
                    alive_n = '1;
                    score_n = 4'd0;
                    lives_n = 2'(LIVES_INIT);
                    gs_n    = READY;
                    pad_n   = PAD_INIT;
                    row_n   = SNAP_ROW;
                    col_n   = PAD_INIT + BALL_OFS;
                end else if (alive_s == '0) begin
                    gs_n = WON;
                end else if (pend && gs_s == READY) begin
                    gs_n       = PLAY;
                    go_down_n  = 1'b0;
                    go_right_n = 1'b1;
                end
            end
            default: phase_n = WAIT;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) begin
            idx         <= 4'd0;
            pad_s       <= PAD_INIT;
            row_s       <= SNAP_ROW;
            col_s       <= PAD_INIT + BALL_OFS;
            alive_s     <= '1;
            score_s     <= 4'd0;
            lives_s     <= 2'(LIVES_INIT);
            gs_s        <= READY;
            go_down     <= 1'b0;
            go_right    <= 1'b1;
            hit_done    <= 1'b0;
            pend        <= 1'b0;
            paddle_x    <= PAD_INIT[9:0];
            ball_row    <= SNAP_ROW[8:0];
            ball_col    <= 10'(PAD_INIT + BALL_OFS);
            brick_alive <= '1;
            score       <= 4'd0;
            lives       <= 2'(LIVES_INIT);
            game_state  <= READY;
        end else begin
            idx      <= idx_n;
            pad_s    <= pad_n;
            row_s    <= row_n;
            col_s    <= col_n;
            alive_s  <= alive_n;
            score_s  <= score_n;
            lives_s  <= lives_n;
            gs_s     <= gs_n;
            go_down  <= go_down_n;
            go_right <= go_right_n;
            hit_done <= hit_done_n;
            // A launch arriving on the COMMIT edge survives into the next frame.
            pend     <= ((phase == COMMIT) ? 1'b0 : pend) | launch;
            if (phase == COMMIT) begin
                paddle_x    <= pad_n[9:0];
                ball_row    <= row_n[8:0];
                ball_col    <= col_n[9:0];
                brick_alive <= alive_n;
                score       <= score_n;
                lives       <= lives_n;
                game_state  <= gs_n;
            end
        end
endmodule
